// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// the beat counter width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Counter must hold values 0..max_burst inclusive.
  function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write-port arbiter.
// slave is the arbiter view, master is the producer/FIFO environment view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE_DATA = 8
);

  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic [NUM_REQ-1:0]           o_grant;
  logic                         o_busy;
  logic                         o_fifo_wr_en;
  logic [SIZE_DATA-1:0]         o_fifo_data;
  logic                         i_fifo_full;

  modport slave (
    input  i_req_valid, i_req_data, i_fifo_full,
    output o_req_ready, o_grant, o_busy, o_fifo_wr_en, o_fifo_data
  );

  modport master (
    output i_req_valid, i_req_data, i_fifo_full,
    input  o_req_ready, o_grant, o_busy, o_fifo_wr_en, o_fifo_data
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NUM_REQ. Shared with the read-side scheduler.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         pick_o,
  output logic                       any_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        pick_o[pos[IDX_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_array write port among NUM_REQ
// producers, with bounded bursts and FIFO-full back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = beat_cnt_width(MAX_BURST);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]     beat_cnt_q;

  logic [NUM_REQ-1:0]   pick;
  logic                 any_req;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic                 busy;
  logic                 g_valid;
  logic                 accept;
  logic                 last_beat;
  logic                 release_burst;

  logic [NUM_REQ-1:0]   ready_c;
  logic                 wr_en_c;
  logic [SIZE_DATA-1:0] data_c;

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i (bus.i_req_valid),
    .ptr_i (rr_ptr_q),
    .pick_o(pick),
    .any_o (any_req)
  );

  // One-hot pick to index, kept alongside grant_q to drive the data mux.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign busy          = (state_q == ST_BURST);
  assign g_valid       = bus.i_req_valid[gidx_q];
  assign accept        = busy & g_valid & ~bus.i_fifo_full;
  assign last_beat     = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_burst = busy & (~g_valid | (accept & last_beat));
  assign rr_ptr_d      = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q    <= ST_BURST;
            grant_q    <= pick;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ST_BURST: begin
          // A full FIFO freezes everything here; only a dropped valid releases.
          if (accept) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          if (release_burst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
      endcase
    end
  end

  // Zero-cycle path from i_fifo_full; fifo_array drives o_full from a register.
  always_comb begin
    ready_c = '0;
    wr_en_c = 1'b0;
    data_c  = '0;
    if (busy) begin
      ready_c[gidx_q] = ~bus.i_fifo_full;
      wr_en_c         = accept;
      data_c          = bus.i_req_data[gidx_q*SIZE_DATA +: SIZE_DATA];
    end
  end

  assign bus.o_req_ready  = ready_c;
  assign bus.o_fifo_wr_en = wr_en_c;
  assign bus.o_fifo_data  = data_c;
  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, round-robin order,
// full stall, early drop and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .SIZE_DATA(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NR),
    .SIZE_DATA(DW),
    .MAX_BURST(MB)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [DW-1:0] dat [NR];
  logic [DW-1:0] wlog [$];
  logic [DW-1:0] exp_q [$];
  int            glog [$];

  logic [NR-1:0] s_grant, s_ready, last_grant;
  logic          s_wr, s_busy;
  logic [DW-1:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_data();
    for (int k = 0; k < NR; k++) bus.i_req_data[k*DW +: DW] = dat[k];
  endtask

  // One cycle: drive at negedge, sample combinational/registered outputs 1ns later.
  task automatic step(input logic [NR-1:0] v, input logic full);
    @(negedge clk);
    bus.i_req_valid = v;
    bus.i_fifo_full = full;
    drive_data();
    #1;
    s_grant = bus.o_grant;
    s_ready = bus.o_req_ready;
    s_wr    = bus.o_fifo_wr_en;
    s_busy  = bus.o_busy;
    s_data  = bus.o_fifo_data;
    if (s_wr) wlog.push_back(s_data);
    for (int k = 0; k < NR; k++) begin
      if (v[k] && s_ready[k]) dat[k] = dat[k] + DW'(1);
    end
    if (s_grant != '0 && s_grant != last_grant) begin
      for (int k = 0; k < NR; k++) if (s_grant[k]) glog.push_back(k);
    end
    last_grant = s_grant;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.i_req_valid = '0;
    bus.i_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
    glog.delete();
    last_grant = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    last_grant = '0;
    for (int k = 0; k < NR; k++) dat[k] = '0;

    // Reset with every requester asserting valid.
    rst_n           = 1'b0;
    bus.i_req_valid = '1;
    bus.i_fifo_full = 1'b0;
    drive_data();
    @(negedge clk);
    #1;
    check("rst_grant", 32'(bus.o_grant), 32'h0);
    check("rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    check("rst_ready", 32'(bus.o_req_ready), 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'h0);
    check("rst_data", 32'(bus.o_fifo_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_first_grant", 32'(bus.o_grant), 32'h1);
    check("rst_first_busy", 32'(bus.o_busy), 32'h1);

    // Single requester 2, continuous.
    do_reset();
    dat[2] = 8'h10;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0);
      check($sformatf("single_wr_%0d", i), 32'(s_wr), (i == 0 || i == 5) ? 32'h0 : 32'h1);
      if (i == 5) check("single_gap_ready", 32'(s_ready), 32'h0);
      if (i == 1) check("single_grant", 32'(s_grant), 32'h4);
    end
    check("single_count", 32'(wlog.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("single_data_%0d", j), 32'(wlog[j]), 32'h10 + 32'(j));
    end

    // All four continuously valid: round-robin 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < NR; k++) dat[k] = DW'(k << 4);
    for (int i = 0; i < 22; i++) step(4'b1111, 1'b0);
    check("rr_grants", 32'(glog.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rr_grant_%0d", j), 32'(glog[j]), 32'(j % 4));
    end
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(DW'((r << 4) | b));
    exp_q.push_back(8'h04);
    check("rr_count", 32'(wlog.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("rr_data_%0d", j), 32'(wlog[j]), 32'(exp_q[j]));
    end

    // Full stall after beat 2.
    do_reset();
    dat[1] = 8'hA0;
    repeat (3) step(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b1);
      check($sformatf("stall_wr_%0d", i), 32'(s_wr), 32'h0);
      check($sformatf("stall_grant_%0d", i), 32'(s_grant), 32'h2);
    end
    check("stall_beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
    check("stall_ready", 32'(s_ready), 32'h0);
    check("stall_data", 32'(s_data), 32'hA2);
    repeat (2) step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    check("stall_release_grant", 32'(s_grant), 32'h0);
    check("stall_release_busy", 32'(s_busy), 32'h0);
    check("stall_count", 32'(wlog.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stall_data_%0d", j), 32'(wlog[j]), 32'hA0 + 32'(j));
    end

    // Early drop by requester 1, then 3 beats 0 from rr_ptr=2.
    do_reset();
    dat[0] = 8'hE0;
    dat[1] = 8'hB0;
    dat[3] = 8'hD0;
    repeat (3) step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    check("drop_wr", 32'(s_wr), 32'h0);
    step(4'b1001, 1'b0);
    check("drop_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    check("drop_idle_grant", 32'(s_grant), 32'h0);
    step(4'b1001, 1'b0);
    check("drop_next_grant", 32'(s_grant), 32'h8);
    check("drop_next_data", 32'(s_data), 32'hD0);
    check("drop_next_wr", 32'(s_wr), 32'h1);

    // Reset asserted while the fourth beat is presented.
    do_reset();
    dat[2] = 8'hC0;
    repeat (4) step(4'b0100, 1'b0);
    @(negedge clk);
    bus.i_req_valid = 4'b0100;
    drive_data();
    rst_n = 1'b0;
    #1;
    check("mrst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    check("mrst_ready", 32'(bus.o_req_ready), 32'h0);
    check("mrst_grant", 32'(bus.o_grant), 32'h0);
    check("mrst_count", 32'(wlog.size()), 32'd3);
    @(negedge clk);
    bus.i_req_valid = '1;
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    check("mrst_restart_grant", 32'(s_grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of a `fifo_array` instance. It grants one requester at a time for a bounded burst, forwards that requester's data to the FIFO, and applies FIFO back-pressure (`o_full`) as per-requester ready. It sits directly in front of `fifo_array` on the write side. The FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `SIZE_DATA`, default 8: data width; matches `fifo_array.SIZE_DATA`.
- `MAX_BURST`, default 4: maximum accepted beats per grant; must be ≥ 1.

Ports (reset is asynchronous, active-low, on `i_rst_n`; one clock `i_clk`):
- `i_clk` input 1: single clock; all state updates on its rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_req_valid` input NUM_REQ: per-requester data-valid.
- `i_req_data` input NUM_REQ*SIZE_DATA: packed data; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA].
- `o_req_ready` output NUM_REQ: per-requester accept; a beat transfers when valid && ready.
- `o_grant` output NUM_REQ: registered one-hot current grant; all-zero when idle.
- `o_busy` output 1: high while in ST_BURST.
- `o_fifo_wr_en` output 1: drives `fifo_array.i_wr_en`.
- `o_fifo_data` output SIZE_DATA: drives `fifo_array.i_data`.
- `i_fifo_full` input 1: driven from `fifo_array.o_full`.

## Operation
- Two-state FSM:
  - ST_IDLE → ST_BURST when any `i_req_valid` bit is high.
  - ST_BURST → ST_IDLE on release.
- Arbitration happens in ST_IDLE. The winner is the first valid requester found searching upward from `rr_ptr`, wrapping modulo NUM_REQ. The winner is registered into `o_grant`.
- In ST_BURST with granted index g:
  - `o_req_ready[g] = ~i_fifo_full`; all other ready bits are 0.
  - `o_fifo_wr_en = i_req_valid[g] & ~i_fifo_full`.
  - `o_fifo_data = i_req_data[g]`, a combinational mux. It is driven with g's data even when `o_fifo_wr_en` = 0.
- Beat counter `beat_cnt` is $clog2(MAX_BURST+1) bits wide. It clears on grant and increments on each accepted beat.
- Release conditions (next state ST_IDLE):
  - (a) The accepted beat brings `beat_cnt` to MAX_BURST.
  - (b) `i_req_valid[g]` = 0 in any ST_BURST cycle.
- On release, `rr_ptr` ← (g+1) mod NUM_REQ, and `o_grant` clears to 0.
- Full FIFO stalls the burst: the grant is held, the counter is frozen, and nothing is written. There is no timeout.
- In ST_IDLE, all ready bits and `o_fifo_wr_en` are 0.
- No data is ever dropped or duplicated. Every accepted beat produces exactly one FIFO write in the same cycle.

## Timing
- Reset values: state ST_IDLE, `rr_ptr` = 0, `beat_cnt` = 0, `o_grant` = 0, `o_busy` = 0. This forces `o_req_ready` = 0, `o_fifo_wr_en` = 0 and `o_fifo_data` = 0.
- Arbitration latency: valid seen in ST_IDLE at edge n gives grant visible after edge n. The first beat can transfer in the cycle following edge n.
- Bursts are separated by exactly one ST_IDLE cycle. Sustained throughput is therefore MAX_BURST/(MAX_BURST+1) beats per cycle.
- `i_fifo_full` → ready/`wr_en` is a zero-cycle combinational path. Because `fifo_array` updates `o_full` from registers, the path contains no loop.
- A requester may drop valid mid-burst; release follows at the next edge.
- Valid from the granted requester reappearing during the release cycle is not accepted; that requester re-arbitrates in ST_IDLE.
- Reset asserted mid-burst clears all state immediately; no further write is issued. Beats already written remain in the FIFO, whose reset is independent.
- Simultaneous requests are resolved by `rr_ptr` only; there is no fixed priority.

## Structure
- Shared package/header `fifo_arb_pkg`: state encodings ST_IDLE = 1'b0, ST_BURST = 1'b1, and the `beat_cnt` width function.
- Sub-module `rr_priority_pick`: purely combinational. Inputs are a NUM_REQ request vector and a `rr_ptr` start index. Outputs are a one-hot pick and an any-request flag. It is reusable for the FIFO read-side scheduler.
- Top `fifo_wr_arbiter` contains the FSM, `beat_cnt`, `rr_ptr`, grant register and data mux.

## Test plan
- Reset:
  - Stimulus: assert `i_rst_n` = 0 with all valids high.
  - Required: `o_grant` = 0, `o_fifo_wr_en` = 0, all ready = 0.
  - Stimulus: release reset.
  - Required: requester 0 granted one cycle later.
- Single requester, continuous:
  - Stimulus: requester 2 holds valid with data 0x10, 0x11, …; MAX_BURST = 4, FIFO not full.
  - Required: four writes (0x10–0x13), one idle cycle, then 0x14 onward.
- All four requesters valid continuously, each tagged with its index in the high nibble.
  - Required: grant order 0, 1, 2, 3, 0, with four beats each.
  - Required: the FIFO read-back sequence matches exactly.
- Full stall:
  - Stimulus: hold `i_fifo_full` = 1 for 5 cycles after beat 2 of a burst.
  - Required: grant is held, no writes occur, and `beat_cnt` stays at 2.
  - Required: after full drops, beats 3–4 are written and then release occurs.
- Early drop:
  - Stimulus: requester 1 gives 2 beats, then valid = 0.
  - Required: release at the next edge; `rr_ptr` = 2; requester 3 wins over requester 0 when both are valid.
- Mid-burst reset:
  - Stimulus: assert `i_rst_n` = 0 after beat 3.
  - Required: `o_fifo_wr_en` drops immediately and exactly 3 beats are written.
  - Required: after reset, arbitration restarts from index 0.
